trng_ctrl: RTL
==============

// Module: trng_ctrl
// PURPOSE
//  Sequences the external TRNG (trng_req/trng_bit) and shares it between N_REQ on-chip consumers (e.g. pwhash salt/nonce).
//  Paces raw-bit sampling, assembles WORD_W-bit words, and delivers each word to one granted requester.
//  Runs a continuous repetition-count health test on raw bits. Sits between the fpga top-level TRNG pins and pwhash.
// PARAMETERS
//  N_REQ       2   number of requesters (>=2)
//  WORD_W      8   bits per delivered word
//  SETTLE_CYC  4   cycles trng_req is held high before each sample (>=1)
//  REP_LIMIT   16  consecutive identical raw bits that trip health_fail (>=2)
// PORTS
//  clk          in   1              system clock
//  resetn       in   1              asynchronous, active-low reset
//  req          in   N_REQ          per-requester word request, held until vld or abandoned
//  vld          out  N_REQ          one-cycle pulse: rd_data valid for that requester
//  rd_data      out  WORD_W         shared word bus; meaningful only when some vld bit is high
//  trng_bit     in   1              raw TRNG bit, already synchronised at top level
//  trng_req     out  1              TRNG enable/strobe to the entropy source
//  health_clr   in   1              clears sticky health failure
//  health_fail  out  1              sticky repetition-test failure
//  busy         out  1              high in every state except IDLE and FAIL
// BEHAVIOUR
//  Reset (async, any state): vld=0, rd_data=0, trng_req=0, health_fail=0, busy=0, shift/bit/rep counters=0, RR pointer -> requester 0 preferred, state IDLE.
//  States: IDLE, SETTLE, REST, DELIVER, FAIL.
//  IDLE: when any req high, grant = first requester at/after RR pointer; grant registered; next cycle SETTLE.
//  SETTLE: trng_req=1 for SETTLE_CYC cycles; trng_bit sampled on the last of them; then REST.
//  REST: trng_req=0 for 1 cycle. Accepted bit shifts in LSB: sh <= {sh[WORD_W-2:0], bit}.
//   Fewer than WORD_W bits accepted -> SETTLE; otherwise -> DELIVER.
//  DELIVER: vld[grant]=1 and rd_data=sh for exactly 1 cycle; RR pointer <= grant+1 (mod N_REQ); bit count cleared; -> IDLE.
//  Latency without debias: req seen in IDLE at cycle 0 -> vld at cycle 1 + WORD_W*(SETTLE_CYC+1).
//  Abandon: granted req drops during SETTLE/REST -> next cycle IDLE, trng_req=0, partial bits discarded, no vld, RR pointer unchanged.
//  Other requesters' req changes during a word are ignored until IDLE. Requester holding req after vld is regranted only per RR order.
//  Health: every raw sample (including pairs discarded by debias) compared with previous raw sample; equal -> rep count+1, else rep count=1.
//   rep count reaching REP_LIMIT -> health_fail=1 and state FAIL at next edge; any in-flight word discarded, no vld.
//  FAIL: trng_req=0, vld=0, busy=0, all req ignored. health_clr=1 -> health_fail=0, rep count=0, state IDLE next cycle.
//   health_clr outside FAIL only resets rep count. Rep count is not cleared at word boundaries.
//  Counters sized $clog2(max+1); no wrap is ever reachable (rep count saturates at REP_LIMIT).
// CONFIGURATION
//  TRNG_VN_DEBIAS_EN defined: von Neumann debiasing. Raw samples taken in pairs (two SETTLE/REST rounds).
//   01 -> accept 0, 10 -> accept 1, 00/11 -> discard pair. Word latency variable, >= 2*WORD_W*(SETTLE_CYC+1)+1.
//  Not defined: every raw sample accepted directly; fixed latency above.
// STRUCTURE
//  trng_ctrl_pkg: state enum (IDLE, SETTLE, REST, DELIVER, FAIL), width helper constants, debias pair decode function.
//  Sub-module trng_rr_arb: N_REQ-way round-robin grant from req and pointer, combinational plus pointer register.
//  trng_ctrl holds the FSM, settle counter, shift register, bit counter, health test, and debias pair register.
// TESTING
//  1. req=2'b01, trng_bit pattern 1,0,1,1,0,0,1,0 -> vld[0] pulse at cycle 41, rd_data=8'hB2, trng_req high 4 of every 5 cycles.
//  2. req=2'b11 held -> words granted 0,1,0,1; never two consecutive grants to the same requester.
//  3. Drop req[0] mid-word (cycle 12) -> trng_req=0 next cycle, no vld, next grant is still requester 0 if it re-requests first.
//  4. trng_bit stuck 1 for 16 samples -> health_fail=1, FAIL, no vld; health_clr pulse -> IDLE, new words delivered.
//  5. resetn low mid-SETTLE -> all outputs 0 immediately; after release, first grant goes to requester 0.
//  6. TRNG_VN_DEBIAS_EN: raw 0,1, 1,1, 1,0, ... -> accepted bits 0,1; 11 pair discarded; rd_data matches model.

Source files
------------

// File: rtl/trng_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// trng_ctrl_pkg
// Shared types and helpers for the TRNG controller:
//   state_e    - controller FSM states
//   cnt_w()    - counter width able to hold 0..max_val
//   vn_res_t   - result of a von Neumann pair decode
//   vn_decode()- 01 -> accept 0, 10 -> accept 1, 00/11 -> reject
// No ports (package).
// ----------------------------------------------------------------------------
package trng_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_REST,
        ST_DELIVER,
        ST_FAIL
    } state_e;

    function automatic int cnt_w(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    typedef struct packed {
        logic ok;     // pair carries a usable bit
        logic bit_v;  // the accepted bit
    } vn_res_t;

    // The first bit of an unequal pair is the accepted bit (10 -> 1, 01 -> 0).
    function automatic vn_res_t vn_decode(input logic first, input logic second);
        vn_res_t r;
        r.ok    = first ^ second;
        r.bit_v = first;
        return r;
    endfunction

endpackage

// File: rtl/trng_ctrl_if.sv
// ----------------------------------------------------------------------------
// trng_ctrl_if
// Consumer-side word bus of the TRNG controller.
//   req     [N_REQ]  per-requester word request (held until vld or abandoned)
//   vld     [N_REQ]  one-cycle pulse, rd_data valid for that requester
//   rd_data [WORD_W] shared word bus
// Modports: master = consumers, slave = trng_ctrl.
// ----------------------------------------------------------------------------
interface trng_ctrl_if #(
    parameter int N_REQ  = 2,
    parameter int WORD_W = 8
) ();
    logic [N_REQ-1:0]  req;
    logic [N_REQ-1:0]  vld;
    logic [WORD_W-1:0] rd_data;

    modport master (output req, input  vld, input  rd_data);
    modport slave  (input  req, output vld, output rd_data);
endinterface

// File: rtl/trng_rr_arb.sv
// ----------------------------------------------------------------------------
// trng_rr_arb
// N_REQ-way round-robin selector. Grant is combinational: the first requester
// at or after the pointer. The pointer moves past a requester only when told
// (a word was actually delivered), so abandoned words do not rotate priority.
// Ports:
//   clk, resetn  clock, async active-low reset (pointer -> requester 0)
//   req_i        request vector
//   adv_i        advance pointer to adv_idx_i + 1 (mod N_REQ)
//   adv_idx_i    requester that was just served
//   gnt_vld_o    some requester is selected
//   gnt_idx_o    selected requester index
// ----------------------------------------------------------------------------
module trng_rr_arb #(
    parameter int N_REQ = 2,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [N_REQ-1:0] req_i,
    input  logic             adv_i,
    input  logic [IDX_W-1:0] adv_idx_i,
    output logic             gnt_vld_o,
    output logic [IDX_W-1:0] gnt_idx_o
);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_REQ - 1);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] j;

    always_comb begin
        gnt_vld_o = 1'b0;
        gnt_idx_o = ptr_q;
        j         = '0;
        for (int k = 0; k < N_REQ; k++) begin
            j = IDX_W'((int'(ptr_q) + k) % N_REQ);
            if (!gnt_vld_o && req_i[j]) begin
                gnt_vld_o = 1'b1;
                gnt_idx_o = j;
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (adv_i) ptr_d = (adv_idx_i == LAST) ? '0 : adv_idx_i + 1'b1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) ptr_q <= '0;
        else         ptr_q <= ptr_d;
    end
endmodule

// File: rtl/trng_ctrl.sv
// ----------------------------------------------------------------------------
// trng_ctrl
// Sequences an external TRNG and shares it between N_REQ consumers. Each raw
// sample is taken after trng_req has been high SETTLE_CYC cycles, followed by
// one rest cycle; WORD_W accepted bits form a word delivered to the granted
// requester. A repetition-count health test on raw samples trips a sticky
// failure that blocks all service until health_clr.
// Optional build macro: TRNG_VN_DEBIAS_EN (von Neumann debiasing of raw pairs).
// Ports:
//   clk, resetn   clock, async active-low reset
//   bus           trng_ctrl_if.slave (req in, vld/rd_data out)
//   trng_bit      raw synchronised TRNG bit
//   trng_req      TRNG enable strobe
//   health_clr    clears the sticky failure (in FAIL) / repetition count
//   health_fail   sticky repetition-test failure
//   busy          high in SETTLE, REST, DELIVER
// ----------------------------------------------------------------------------
module trng_ctrl
    import trng_ctrl_pkg::*;
#(
    parameter int N_REQ      = 2,
    parameter int WORD_W     = 8,
    parameter int SETTLE_CYC = 4,
    parameter int REP_LIMIT  = 16
) (
    input  logic       clk,
    input  logic       resetn,
    trng_ctrl_if.slave bus,
    input  logic       trng_bit,
    output logic       trng_req,
    input  logic       health_clr,
    output logic       health_fail,
    output logic       busy
);
    localparam int IDX_W = $clog2(N_REQ);
    localparam int SC_W  = cnt_w(SETTLE_CYC);
    localparam int BC_W  = cnt_w(WORD_W);
    localparam int RP_W  = cnt_w(REP_LIMIT);

    localparam logic [SC_W-1:0] SC_LAST = SC_W'(SETTLE_CYC - 1);
    localparam logic [BC_W-1:0] BC_LAST = BC_W'(WORD_W - 1);
    localparam logic [RP_W-1:0] RP_MAX  = RP_W'(REP_LIMIT);

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  grant_q, grant_d, arb_idx;
    logic              arb_vld;
    logic [SC_W-1:0]   sc_q, sc_d;
    logic [BC_W-1:0]   bc_q, bc_d;
    logic [WORD_W-1:0] sh_q, sh_d;
    logic [RP_W-1:0]   rep_q, rep_d;
    logic              prev_q, prev_d;
    logic              hfail_q, hfail_d;
    logic              acc_vld_q, acc_vld_d;
    logic              acc_bit_q, acc_bit_d;
`ifdef TRNG_VN_DEBIAS_EN
    logic              ph_q, ph_d;        // 1: first bit of a pair is held
    logic              first_q, first_d;
    vn_res_t           vn;
`endif

    logic req_g, settle_last, smp, trip;

    assign req_g       = bus.req[grant_q];
    assign settle_last = (sc_q == SC_LAST);
    assign smp         = (state_q == ST_SETTLE) && settle_last;

    trng_rr_arb #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_arb (
        .clk       (clk),
        .resetn    (resetn),
        .req_i     (bus.req),
        .adv_i     (state_q == ST_DELIVER),
        .adv_idx_i (grant_q),
        .gnt_vld_o (arb_vld),
        .gnt_idx_o (arb_idx)
    );

    // Health test: runs on every raw sample, independent of word boundaries.
    // health_clr wins over a coincident sample.
    always_comb begin
        rep_d   = rep_q;
        prev_d  = prev_q;
        hfail_d = hfail_q;
        trip    = 1'b0;
        if (smp) prev_d = trng_bit;
        if (health_clr) begin
            rep_d = '0;
            if (state_q == ST_FAIL) hfail_d = 1'b0;
        end else if (smp) begin
            if (rep_q == '0 || trng_bit != prev_q) rep_d = RP_W'(1);
            else if (rep_q != RP_MAX)              rep_d = rep_q + 1'b1;
            if (rep_d == RP_MAX) begin
                trip    = 1'b1;
                hfail_d = 1'b1;
            end
        end
    end

    // FSM: state register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= ST_IDLE;
        else         state_q <= state_d;
    end

    // FSM: next state. Failure beats abandon, abandon beats progress.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (arb_vld) state_d = ST_SETTLE;
            ST_SETTLE: begin
                if (trip)             state_d = ST_FAIL;
                else if (!req_g)      state_d = ST_IDLE;
                else if (settle_last) state_d = ST_REST;
            end
            ST_REST: begin
                if (!req_g)                          state_d = ST_IDLE;
                else if (acc_vld_q && bc_q == BC_LAST) state_d = ST_DELIVER;
                else                                 state_d = ST_SETTLE;
            end
            ST_DELIVER: state_d = ST_IDLE;
            ST_FAIL:    if (health_clr) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs (Moore, so async reset forces all of them low at once)
    always_comb begin
        bus.vld     = '0;
        bus.rd_data = '0;
        trng_req    = 1'b0;
        busy        = 1'b0;
        case (state_q)
            ST_SETTLE: begin
                trng_req = 1'b1;
                busy     = 1'b1;
            end
            ST_REST:   busy = 1'b1;
            ST_DELIVER: begin
                busy              = 1'b1;
                bus.vld[grant_q]  = 1'b1;
                bus.rd_data       = sh_q;
            end
            default: ;
        endcase
    end

    assign health_fail = hfail_q;

    // Datapath. IDLE and FAIL clear all word state, which is what discards a
    // partial word on abandon or failure.
    always_comb begin
        grant_d   = grant_q;
        sc_d      = sc_q;
        bc_d      = bc_q;
        sh_d      = sh_q;
        acc_vld_d = acc_vld_q;
        acc_bit_d = acc_bit_q;
`ifdef TRNG_VN_DEBIAS_EN
        ph_d      = ph_q;
        first_d   = first_q;
        vn        = vn_decode(first_q, trng_bit);
`endif
        case (state_q)
            ST_IDLE, ST_FAIL: begin
                sc_d = '0;
                bc_d = '0;
                sh_d = '0;
`ifdef TRNG_VN_DEBIAS_EN
                ph_d = 1'b0;
`endif
                if (state_q == ST_IDLE && arb_vld) grant_d = arb_idx;
            end
            ST_SETTLE: begin
                sc_d = settle_last ? '0 : sc_q + 1'b1;
                if (smp) begin
`ifdef TRNG_VN_DEBIAS_EN
                    if (!ph_q) begin
                        ph_d      = 1'b1;
                        first_d   = trng_bit;
                        acc_vld_d = 1'b0;
                    end else begin
                        ph_d      = 1'b0;
                        acc_vld_d = vn.ok;
                        acc_bit_d = vn.bit_v;
                    end
`else
                    acc_vld_d = 1'b1;
                    acc_bit_d = trng_bit;
`endif
                end
            end
            ST_REST: begin
                if (acc_vld_q) begin
                    sh_d = {sh_q[WORD_W-2:0], acc_bit_q};
                    bc_d = bc_q + 1'b1;
                end
            end
            ST_DELIVER: bc_d = '0;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            grant_q   <= '0;
            sc_q      <= '0;
            bc_q      <= '0;
            sh_q      <= '0;
            rep_q     <= '0;
            prev_q    <= 1'b0;
            hfail_q   <= 1'b0;
            acc_vld_q <= 1'b0;
            acc_bit_q <= 1'b0;
`ifdef TRNG_VN_DEBIAS_EN
            ph_q      <= 1'b0;
            first_q   <= 1'b0;
`endif
        end else begin
            grant_q   <= grant_d;
            sc_q      <= sc_d;
            bc_q      <= bc_d;
            sh_q      <= sh_d;
            rep_q     <= rep_d;
            prev_q    <= prev_d;
            hfail_q   <= hfail_d;
            acc_vld_q <= acc_vld_d;
            acc_bit_q <= acc_bit_d;
`ifdef TRNG_VN_DEBIAS_EN
            ph_q      <= ph_d;
            first_q   <= first_d;
`endif
        end
    end
endmodule
